// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel time-setting controller.
// Debounces the mode and increment buttons, then walks an edit sequence
// (hours, then minutes, then commit). The edited BCD digits and a one-cycle
// load strobe go to the watch counter. Field-select and blink flags let the
// display flash the field being edited.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | not editing; a mode press captures *_now and starts editing
// EDIT_HOUR | inc advances hours 00..23; mode moves on to minutes
// EDIT_MIN  | inc advances minutes 00..59; mode moves on to commit
// COMMIT    | load high for one cycle, then back to IDLE
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   btn_mode, btn_inc            raw asynchronous push-buttons
//   hourdec_now..minone_now      current time from the watch (BCD)
//   hourdec_set..minone_set      edited time (BCD)
//   load                         one-cycle strobe to copy *_set
//   edit_hour, edit_min          field being edited
//   blink                        display blink phase while editing
module time_set_ctrl #(
  parameter int DEB_CNT   = 16,
  parameter int TIMEOUT   = 1000000,
  parameter int BLINK_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [3:0] hourdec_set,
  output logic [3:0] hourone_set,
  output logic [3:0] mindec_set,
  output logic [3:0] minone_set,
  output logic       load,
  output logic       edit_hour,
  output logic       edit_min,
  output logic       blink
);

  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_CNT + 1);

  typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

  // Button index 0 = mode, 1 = inc.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, deb, press;
  logic [DW-1:0] deb_cnt [2];
  logic          mode_ev, inc_ev;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;

  assign raw     = {btn_inc, btn_mode};
  assign mode_ev = press[0];
  assign inc_ev  = press[1];

  // The press pulse is raised on the same edge the debounced level rises,
  // so press-to-event latency is two sync stages plus DEB_CNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DW'(DEB_CNT - 1)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
            press[i]   <= sync2[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Any out-of-range value (including a digit above 9) wraps to 00.
  function automatic logic [7:0] hour_next(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u >= 4'd3)) return 8'h00;
    else if (u == 4'd9) return {t + 4'd1, 4'd0};
    else return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] min_next(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd5 || u > 4'd9 || (t == 4'd5 && u == 4'd9)) return 8'h00;
    else if (u == 4'd9) return {t + 4'd1, 4'd0};
    else return {t, u + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hourdec_set <= '0;
      hourone_set <= '0;
      mindec_set  <= '0;
      minone_set  <= '0;
      load        <= 1'b0;
      edit_hour   <= 1'b0;
      edit_min    <= 1'b0;
      blink       <= 1'b0;
      tmo_cnt     <= '0;
      blink_cnt   <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          tmo_cnt   <= '0;
          if (mode_ev) begin
            hourdec_set <= hourdec_now;
            hourone_set <= hourone_now;
            mindec_set  <= mindec_now;
            minone_set  <= minone_now;
            edit_hour   <= 1'b1;
            tmo_cnt     <= TW'(TIMEOUT - 1);
            blink_cnt   <= BW'(BLINK_CNT - 1);
            state       <= EDIT_HOUR;
          end
        end
        EDIT_HOUR, EDIT_MIN: begin
          // Blink runs continuously across both edit fields.
          if (blink_cnt == '0) begin
            blink     <= ~blink;
            blink_cnt <= BW'(BLINK_CNT - 1);
          end else begin
            blink_cnt <= blink_cnt - 1'b1;
          end
          // Mode takes priority; a simultaneous inc is dropped.
          if (mode_ev) begin
            tmo_cnt <= TW'(TIMEOUT - 1);
            if (state == EDIT_HOUR) begin
              edit_hour <= 1'b0;
              edit_min  <= 1'b1;
              state     <= EDIT_MIN;
            end else begin
              edit_min  <= 1'b0;
              load      <= 1'b1;
              blink     <= 1'b0;
              blink_cnt <= '0;
              state     <= COMMIT;
            end
          end else if (inc_ev) begin
            tmo_cnt <= TW'(TIMEOUT - 1);
            if (state == EDIT_HOUR)
              {hourdec_set, hourone_set} <= hour_next(hourdec_set, hourone_set);
            else
              {mindec_set, minone_set} <= min_next(mindec_set, minone_set);
          end else if (tmo_cnt == '0) begin
            edit_hour <= 1'b0;
            edit_min  <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        COMMIT: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          tmo_cnt   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;
  localparam int DEB = 4;
  localparam int TMO = 200;
  localparam int BLK = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  logic [3:0] hourdec_now = '0, hourone_now = '0, mindec_now = '0, minone_now = '0;
  logic [3:0] hourdec_set, hourone_set, mindec_set, minone_set;
  logic load, edit_hour, edit_min, blink;

  time_set_ctrl #(.DEB_CNT(DEB), .TIMEOUT(TMO), .BLINK_CNT(BLK)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .hourdec_set(hourdec_set), .hourone_set(hourone_set),
    .mindec_set(mindec_set), .minone_set(minone_set),
    .load(load), .edit_hour(edit_hour), .edit_min(edit_min), .blink(blink)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];
  logic [18:0] dut_vec;
  assign dut_vec = {hourdec_set, hourone_set, mindec_set, minone_set, load, edit_hour, edit_min};

  // Model state: 0 idle, 1 hour, 2 minute
  logic [3:0] m_hd = '0, m_ho = '0, m_md = '0, m_mo = '0;
  int m_st = 0;

  // Monitor: every change of the observed outputs is one DUT response.
  initial begin
    logic [18:0] prev;
    logic [18:0] e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (dut_vec !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got=%h (no expectation queued)", dut_vec);
        end else begin
          e = exp_q.pop_front();
          if (dut_vec !== e) begin
            errors++;
            $display("FAIL out_change got=%h exp=%h", dut_vec, e);
          end
        end
        prev = dut_vec;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_cur(input bit ld);
    exp_q.push_back({m_hd, m_ho, m_md, m_mo, ld, m_st == 1, m_st == 2});
  endtask

  task automatic hold(input bit m, input bit i);
    @(posedge clk); #1;
    btn_mode = m;
    btn_inc  = i;
    repeat (DEB + 6) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DEB + 6) @(posedge clk);
  endtask

  task automatic model_mode;
    case (m_st)
      0: begin
        m_hd = hourdec_now; m_ho = hourone_now; m_md = mindec_now; m_mo = minone_now;
        m_st = 1; push_cur(1'b0);
      end
      1: begin m_st = 2; push_cur(1'b0); end
      default: begin m_st = 0; push_cur(1'b1); push_cur(1'b0); end
    endcase
  endtask

  task automatic model_inc;
    int v;
    if (m_st == 1) begin
      if (m_hd > 9 || m_ho > 9) v = 0;
      else v = m_hd * 10 + m_ho + 1;
      if (v >= 24) v = 0;
      m_hd = 4'(v / 10); m_ho = 4'(v % 10);
      push_cur(1'b0);
    end else if (m_st == 2) begin
      if (m_md > 9 || m_mo > 9) v = 0;
      else v = m_md * 10 + m_mo + 1;
      if (v >= 60) v = 0;
      m_md = 4'(v / 10); m_mo = 4'(v % 10);
      push_cur(1'b0);
    end
  endtask

  task automatic press_mode; model_mode(); hold(1'b1, 1'b0); endtask
  task automatic press_inc;  model_inc();  hold(1'b0, 1'b1); endtask

  task automatic set_now(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    hourdec_now = a; hourone_now = b; mindec_now = c; minone_now = d;
  endtask

  task automatic measure_blink;
    int n;
    logic b;
    n = 0;
    @(negedge clk);
    b = blink;
    while (blink === b && n < 20) begin @(negedge clk); n++; end
    b = blink;
    n = 0;
    while (blink === b && n < 20) begin @(negedge clk); n++; end
    chk("blink_period", n, BLK);
  endtask

  initial begin
    int pat[15];
    pat = '{1, 2, 3, 1, 2, 3, 1, 1, 3, 2, 2, 3, 1, 2, 3};
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {dut_vec, blink}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Normal edit; inc in IDLE is ignored
    press_inc();
    set_now(4'd1, 4'd2, 4'd5, 4'd8);
    press_mode();
    repeat (12) press_inc();
    press_mode();
    repeat (2) press_inc();
    press_mode();

    // Bounce: only one inc event
    press_mode();
    model_inc();
    @(posedge clk); #1;
    for (int k = 0; k < 15; k++) begin
      btn_inc = (k % 2 == 0);
      repeat (pat[k]) @(posedge clk);
      #1;
    end
    btn_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn_inc = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    press_mode();
    press_mode();

    // Wrap boundaries
    set_now(4'd1, 4'd9, 4'd0, 4'd9);
    press_mode(); press_inc(); press_mode(); press_inc(); press_mode();
    set_now(4'd2, 4'd2, 4'd5, 4'd9);
    press_mode(); press_mode(); press_inc(); press_mode();
    set_now(4'd2, 4'd3, 4'd0, 4'd0);
    press_mode(); press_inc(); press_mode(); press_mode();
    set_now(4'd7, 4'd9, 4'd3, 4'd10);
    press_mode(); press_inc(); press_mode(); press_inc(); press_mode();

    // Timeout, plus blink period
    set_now(4'd0, 4'd5, 4'd3, 4'd0);
    press_mode();
    measure_blink();
    press_inc();
    m_st = 0;
    push_cur(1'b0);
    repeat (TMO + 30) @(posedge clk);
    #1;
    chk("timeout_blink", blink, 0);
    chk("timeout_edit_hour", edit_hour, 0);
    chk("timeout_hold_hours", {hourdec_set, hourone_set}, 8'h06);

    // Simultaneous mode and inc
    set_now(4'd1, 4'd4, 4'd3, 4'd3);
    press_mode();
    m_st = 2;
    push_cur(1'b0);
    hold(1'b1, 1'b1);
    measure_blink();
    press_mode();

    // Reset mid-edit
    press_mode(); press_mode(); press_inc();
    m_hd = '0; m_ho = '0; m_md = '0; m_mo = '0; m_st = 0;
    push_cur(1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_reset", {dut_vec, blink}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel time-setting controller: the writer side of the watch's init interface.
- Debounces two raw push-buttons and walks a small edit FSM (hours field, then minutes field).
- Produces BCD hour/minute digits plus a one-cycle load strobe that the watch counter consumes.
- Also drives field-select and blink flags so the 7-segment display can flash the field being edited.

Parameters:
DEB_CNT, 16, consecutive stable cycles required before a synchronized button level is accepted
TIMEOUT, 1000000, idle cycles in an edit state before editing is aborted without loading
BLINK_CNT, 50000, cycles per blink half-period while editing

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
hourdec_now  input  4  current hour tens from the watch (BCD)
hourone_now  input  4  current hour units
mindec_now  input  4  current minute tens
minone_now  input  4  current minute units
hourdec_set  output  4  edited hour tens (BCD)
hourone_set  output  4  edited hour units
mindec_set  output  4  edited minute tens
minone_set  output  4  edited minute units
load  output  1  one-cycle strobe: watch copies *_set digits
edit_hour  output  1  high in EDIT_HOUR
edit_min  output  1  high in EDIT_MIN
blink  output  1  blink phase, toggles every BLINK_CNT cycles while editing, 0 otherwise

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all *_set=0, load=0, edit_hour=edit_min=0, blink=0; debounce counters, synchronizers and timeout/blink counters cleared. Reset mid-edit discards the edit; no load.
- Input path per button:
  - 2-flop synchronizer, then debouncer: the debounced level changes only after the synchronized value differs from it for DEB_CNT consecutive cycles; any bounce restarts the count.
  - Press event = one-cycle pulse on debounced 0->1. Releases generate no event.
  - Press-to-event latency = 2 + DEB_CNT cycles.
- FSM states and transitions:
  - IDLE:
    - mode event -> EDIT_HOUR; *_set capture the *_now inputs on that same clock edge.
    - inc events are ignored.
  - EDIT_HOUR:
    - inc event: hours (hourdec_set:hourone_set) increment in BCD, 09->10, 19->20, 23->00.
    - mode event -> EDIT_MIN.
  - EDIT_MIN:
    - inc event: minutes increment in BCD, x9->(x+1)0, 59->00.
    - Minute wrap does not carry into hours.
    - mode event -> COMMIT.
  - COMMIT: load=1 for exactly this one cycle; *_set hold their values; next state IDLE unconditionally.
- Simultaneous mode and inc events in the same cycle: mode wins, inc is dropped.
- Timeout:
  - Counter runs in EDIT_HOUR/EDIT_MIN and clears on any mode or inc event and on state entry.
  - Reaching TIMEOUT-1 -> IDLE with no load; *_set keep their last values.
- Blink:
  - Counter clears and blink=0 on entry to EDIT_HOUR from IDLE.
  - blink toggles on every BLINK_CNT-th cycle while in either edit state.
  - In IDLE and COMMIT, blink=0 and the counter is held at 0.
- Outputs: *_set, load, edit_hour, edit_min and blink are all registered; no combinational paths from inputs to outputs.
- *_set change only on capture, on inc in an edit state, or on reset.
- Out-of-range *_now (e.g. 7:9 or x:A) is captured as-is; the first inc normalizes it:
  - hours >=23 -> 00
  - minutes >=59 -> 00
  - any digit >9 treated as wrap -> 00

Test Plan (DEB_CNT=4, TIMEOUT=200, BLINK_CNT=8):
1. Reset mid-operation: rst pulse while in EDIT_MIN -> all outputs 0 asynchronously, IDLE, no load afterwards.
2. Normal edit: *_now=1,2,5,8; press mode -> *_set=1,2,5,8 and edit_hour=1. Press inc x12 -> hours 00. Press mode, inc x2 -> minutes 00. Press mode -> exactly one load cycle with 0,0,0,0, then IDLE.
3. Bounce: btn_inc toggling with 1-3 cycle glitches for 30 cycles, then held high 10 cycles -> exactly one inc event; hours advance by 1.
4. Wrap boundaries: hours 19 -> inc -> 20; 23 -> inc -> 00. Minutes 09 -> 10; 59 -> 00, hours unchanged.
5. Timeout: enter EDIT_HOUR, press inc once, wait 200 cycles -> IDLE, load never asserted, *_set hold the incremented value, blink=0.
6. Simultaneous: mode and inc raised on the same cycle in EDIT_HOUR -> EDIT_MIN with hours unchanged. Also check blink period of 8 cycles per phase.
